// File: rtl/async_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_if
//  Description : Producer/consumer bundle for the async_fifo elastic buffer.
//                master modport : data source/sink side (drives requests).
//                slave  modport : FIFO side (drives status and head word).
//  Signals     : w_data  - write word            (master -> slave)
//                w_inc   - write request         (master -> slave)
//                w_full  - FIFO full flag        (slave  -> master)
//                r_inc   - read (pop) request    (master -> slave)
//                r_data  - head-of-queue word    (slave  -> master)
//                r_empty - FIFO empty flag       (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface async_fifo_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 8
);
    logic [DATA_SIZE-1:0] w_data;
    logic                 w_inc;
    logic                 w_full;
    logic                 r_inc;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_empty;

    modport master (
        output w_data,
        output w_inc,
        input  w_full,
        output r_inc,
        input  r_data,
        input  r_empty
    );

    modport slave (
        input  w_data,
        input  w_inc,
        output w_full,
        input  r_inc,
        output r_data,
        output r_empty
    );
endinterface
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo
//  Description : Single-clock first-word-fall-through FIFO holding up to
//                2^ADDR_SIZE words of DATA_SIZE bits. The head word is always
//                visible on r_data (0 while empty).
//  Ports       : clk  - clock, all state updates on rising edge
//                rst  - asynchronous active-high reset of the pointers
//                bus  - async_fifo_if.slave (w_data, w_inc, w_full,
//                       r_inc, r_data, r_empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module async_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  wire             clk,
    input  wire             rst,
    async_fifo_if.slave     bus
);
    localparam int                 c_depth   = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] c_ptr_one = {{ADDR_SIZE{1'b0}}, 1'b1};

    // Storage is deliberately not reset: the pointers alone define validity.
    logic [DATA_SIZE-1:0] mem_q [c_depth];

    // One extra MSB on each pointer distinguishes full from empty when the
    // low (address) bits coincide.
    logic [ADDR_SIZE:0]   wptr_q, wptr_d;
    logic [ADDR_SIZE:0]   rptr_q, rptr_d;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_we;
    logic                 w_re;

    // Flags come from registered pointers only, so there is no path from the
    // request inputs to any output.
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                     (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);

    // Qualifying against the pre-edge flags gives the required behaviour for
    // simultaneous requests: write wins when empty, read wins when full.
    assign w_we = bus.w_inc && !w_full;
    assign w_re = bus.r_inc && !w_empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_we) begin
            wptr_d = wptr_q + c_ptr_one;
        end
        if (w_re) begin
            rptr_d = rptr_q + c_ptr_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // A write landing in memory while rst is high is harmless: the pointers
    // are held at zero, so the slot reads as empty and is overwritten by the
    // first real write after release.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[wptr_q[ADDR_SIZE-1:0]] <= bus.w_data;
        end
    end

    assign bus.w_full  = w_full;
    assign bus.r_empty = w_empty;
    assign bus.r_data  = w_empty ? '0 : mem_q[rptr_q[ADDR_SIZE-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_async_fifo
//  Description : Directed self-checking bench for async_fifo (8 x 256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo;
    localparam int c_dw = 8;
    localparam int c_aw = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    async_fifo_if #(.DATA_SIZE(c_dw), .ADDR_SIZE(c_aw)) bus ();

    async_fifo #(.DATA_SIZE(c_dw), .ADDR_SIZE(c_aw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_empty,
                               input logic exp_full, input logic [7:0] exp_data);
        check({tag, ".r_empty"}, {31'd0, bus.r_empty}, {31'd0, exp_empty});
        check({tag, ".w_full"},  {31'd0, bus.w_full},  {31'd0, exp_full});
        check({tag, ".r_data"},  {24'd0, bus.r_data},  {24'd0, exp_data});
    endtask

    // Apply one set of requests for a single rising edge; sample 1 unit after it.
    task automatic cycle(input logic wi, input logic [7:0] wd, input logic ri);
        bus.w_inc  = wi;
        bus.w_data = wd;
        bus.r_inc  = ri;
        @(posedge clk);
        #1;
        bus.w_inc  = 1'b0;
        bus.r_inc  = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [6];
        vals = '{8'hFF, 8'h24, 8'h81, 8'h09, 8'h63, 8'h0D};
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b0;
        bus.w_inc  = 1'b0;
        bus.r_inc  = 1'b0;
        bus.w_data = '0;

        // ---------------- reset held with random requests ----------------
        #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.w_inc  = 1'($urandom);
            bus.r_inc  = 1'($urandom);
            bus.w_data = 8'($urandom);
            @(posedge clk);
            #1;
            check_state("reset_hold", 1'b1, 1'b0, 8'h00);
        end
        bus.w_inc = 1'b0;
        bus.r_inc = 1'b0;
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        check_state("reset_release", 1'b1, 1'b0, 8'h00);

        // ---------------- basic ordering ----------------
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vals[i], 1'b0);
            check_state("basic_write", 1'b0, 1'b0, 8'hFF);
        end
        for (int i = 0; i < 6; i++) begin
            check("basic_head", {24'd0, bus.r_data}, {24'd0, vals[i]});
            cycle(1'b0, 8'h00, 1'b1);
            if (i < 5) check_state("basic_pop", 1'b0, 1'b0, vals[i+1]);
            else       check_state("basic_last_pop", 1'b1, 1'b0, 8'h00);
        end
        cycle(1'b0, 8'h00, 1'b1);
        check_state("pop_when_empty", 1'b1, 1'b0, 8'h00);

        // ---------------- full boundary ----------------
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            check("fill_full", {31'd0, bus.w_full}, {31'd0, (i == 255)});
        end
        check_state("full_state", 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 8'hAA, 1'b0);
        check_state("write_when_full", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            check("drain_head", {24'd0, bus.r_data}, i);
            cycle(1'b0, 8'h00, 1'b1);
            check("drain_full", {31'd0, bus.w_full}, 32'd0);
        end
        check_state("drained", 1'b1, 1'b0, 8'h00);

        // ---------------- simultaneous on empty ----------------
        cycle(1'b1, 8'h5A, 1'b1);
        check_state("simul_empty", 1'b0, 1'b0, 8'h5A);
        cycle(1'b0, 8'h00, 1'b1);
        check_state("simul_empty_pop", 1'b1, 1'b0, 8'h00);

        // ---------------- simultaneous on full ----------------
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b0);
        check_state("refill", 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 8'hEE, 1'b1);
        check_state("simul_full", 1'b0, 1'b0, 8'h01);
        for (int i = 1; i < 256; i++) begin
            check("simul_full_drain", {24'd0, bus.r_data}, i);
            cycle(1'b0, 8'h00, 1'b1);
        end
        check_state("simul_full_empty", 1'b1, 1'b0, 8'h00);

        // ---------------- half full streaming with wrap ----------------
        for (int i = 0; i < 128; i++) cycle(1'b1, 8'(i), 1'b0);
        check_state("half_fill", 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 300; c++) begin
            cycle(1'b1, 8'(128 + c), 1'b1);
            check_state("stream", 1'b0, 1'b0, 8'(c + 1));
        end
        for (int k = 0; k < 128; k++) begin
            check("stream_drain", {24'd0, bus.r_data}, (300 + k) % 256);
            cycle(1'b0, 8'h00, 1'b1);
        end
        check_state("stream_empty", 1'b1, 1'b0, 8'h00);

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 3; i++)  cycle(1'b0, 8'h00, 1'b1);
        check_state("pre_reset", 1'b0, 1'b0, 8'h13);
        #2 rst = 1'b1;
        #1;
        check_state("async_reset", 1'b1, 1'b0, 8'h00);
        #1 rst = 1'b0;
        check_state("after_reset", 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 8'h3C, 1'b0);
        check_state("post_reset_write", 1'b0, 1'b0, 8'h3C);
        cycle(1'b0, 8'h00, 1'b1);
        check_state("post_reset_pop", 1'b1, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
